// File: rtl/rf_arb_pkg.sv
// Shared types and sizing helpers for the register-file bus arbiter.
// Also provides default register-file geometry macros when the chip-level defines are absent.
`ifndef RF_AWIDTH
`define RF_AWIDTH 8
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif
`ifndef CHIP_ID
`define CHIP_ID 8'h5A
`endif

package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    localparam int LOCK_CW = 8;

    // Index width that stays at least one bit for degenerate requester counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_bus_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector so the search starts after last_grant,
// priority-encode the lowest set bit, then un-rotate back to a requester index.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic [IDX_W-1:0]     start;
    logic [2*NUM_REQ-1:0] req2;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    always_comb begin
        start = (last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
        req2  = {req, req} >> start;
        rot   = req2[NUM_REQ-1:0];
        off        = '0;
        pick_valid = 1'b0;
        // Descending scan so the lowest rotated position is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off        = IDX_W'(i);
                pick_valid = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        pick_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rf_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port among NUM_REQ requesters,
// with a bounded lock for atomic multi-word sequences. IDLE -> ACCESS -> ACK, all outputs registered.
module rf_bus_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*`RF_AWIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*`RF_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*`RF_MASK-1:0]     req_wmask,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [`RF_WIDTH-1:0]            req_rdata,
    output logic [`RF_AWIDTH-1:0]           rf_addr,
    output logic                            rf_we,
    output logic [`RF_WIDTH-1:0]            rf_wdata,
    output logic [`RF_MASK-1:0]             rf_wmask,
    input  logic [`RF_WIDTH-1:0]            rf_rdata,
    output logic                            busy,
    output logic [idx_w(NUM_REQ)-1:0]       grant_id
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int AW    = `RF_AWIDTH;
    localparam int DW    = `RF_WIDTH;
    localparam int MW    = `RF_MASK;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               lock_valid_q, lock_valid_d;
    logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [AW-1:0]      rf_addr_q, rf_addr_d;
    logic [DW-1:0]      rf_wdata_q, rf_wdata_d;
    logic [MW-1:0]      rf_wmask_q, rf_wmask_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [DW-1:0]      req_rdata_q, req_rdata_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [MW-1:0]      sel_wmask;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_cnt_d   = lock_cnt_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_wmask_d   = rf_wmask_q;
        req_ack_d    = '0;
        req_rdata_d  = req_rdata_q;
        sel_idx      = '0;
        sel_valid    = 1'b0;
        sel_we       = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_wmask    = '0;

        case (state_q)
            IDLE: begin
                if (lock_valid_q && req[idx_q]) begin
                    sel_idx   = idx_q;
                    sel_valid = 1'b1;
                end else begin
                    // A lock holder that stopped requesting forfeits the lock immediately.
                    if (lock_valid_q) begin
                        lock_valid_d = 1'b0;
                        lock_cnt_d   = '0;
                    end
                    sel_idx   = pick_idx;
                    sel_valid = pick_valid;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (sel_idx == IDX_W'(i)) begin
                        sel_we    = req_we[i];
                        sel_addr  = req_addr[i*AW +: AW];
                        sel_wdata = req_wdata[i*DW +: DW];
                        sel_wmask = req_wmask[i*MW +: MW];
                    end
                end
                if (sel_valid) begin
                    idx_d      = sel_idx;
                    rf_we_d    = sel_we;
                    rf_addr_d  = sel_addr;
                    rf_wdata_d = sel_wdata;
                    rf_wmask_d = sel_wmask;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The write lands at this edge, so a write never returns stale pre-write data.
                req_rdata_d = rf_we_q ? '0 : rf_rdata;
                req_ack_d   = NUM_REQ'(1) << idx_q;
                state_d     = ACK;
            end
            ACK: begin
                last_grant_d = idx_q;
                if (req_lock[idx_q] && ((9'(lock_cnt_q) + 9'd1) < 9'(LOCK_MAX))) begin
                    lock_valid_d = 1'b1;
                    lock_cnt_d   = lock_cnt_q + 1'b1;
                end else begin
                    lock_valid_d = 1'b0;
                    lock_cnt_d   = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            lock_valid_q <= 1'b0;
            lock_cnt_q   <= '0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            rf_wmask_q   <= '0;
            req_ack_q    <= '0;
            req_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_cnt_q   <= lock_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_wmask_q   <= rf_wmask_d;
            req_ack_q    <= req_ack_d;
            req_rdata_q  <= req_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign req_rdata = req_rdata_q;
    assign rf_addr   = rf_addr_q;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_wmask  = rf_wmask_q;
    assign busy      = busy_q;
    assign grant_id  = idx_q;

endmodule

// File: tb/tb_rf_bus_arbiter.sv
// Directed bench for rf_bus_arbiter with three requesters and a small register-file model
// (registered masked write, combinational read, address 0 returns the chip ID).
module tb_rf_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = `RF_AWIDTH;
    localparam int DW = `RF_WIDTH;
    localparam int MW = `RF_MASK;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*MW-1:0] req_wmask = '0;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   req_rdata;
    logic [AW-1:0]   rf_addr;
    logic            rf_we;
    logic [DW-1:0]   rf_wdata;
    logic [MW-1:0]   rf_wmask;
    logic [DW-1:0]   rf_rdata;
    logic            busy;
    logic [1:0]      grant_id;

    logic [DW-1:0]   mem [256] = '{default: '0};
    logic [7:0]      chip_id = `CHIP_ID;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_bus_arbiter #(.NUM_REQ(N), .LOCK_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .rf_addr   (rf_addr),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_wmask  (rf_wmask),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always @(posedge clk) begin
        if (rf_we) begin
            for (int b = 0; b < MW; b++) begin
                if (rf_wmask[b]) mem[rf_addr][b*8 +: 8] <= rf_wdata[b*8 +: 8];
            end
        end
    end

    assign rf_rdata = (rf_addr == '0) ? {{(DW-8){1'b0}}, chip_id} : mem[rf_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic lk, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req[i]               = r;
        req_lock[i]          = lk;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wmask[i*MW +: MW] = m;
    endtask

    task automatic wait_ack(output logic [N-1:0] ack, output int cyc);
        bit done = 0;
        ack = '0;
        cyc = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
            if (req_ack != '0) begin
                ack  = req_ack;
                done = 1;
            end
        end
    endtask

    task automatic settle();
        req = '0;
        req_lock = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_cmp++; if (rf_we !== 1'b0) begin $display("FAIL rst_rf_we: got %b want 0", rf_we); n_bad++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_bad++; end
        n_cmp++; if (req_ack !== 3'b000) begin $display("FAIL rst_ack: got %b want 000", req_ack); n_bad++; end
        rst = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL idle_busy: got %b want 0", busy); n_bad++; end
        n_cmp++; if (req_ack !== 3'b000) begin $display("FAIL idle_ack: got %b want 000", req_ack); n_bad++; end
        n_cmp++; if (req_rdata !== 32'h0) begin $display("FAIL idle_rdata: got %h want 0", req_rdata); n_bad++; end
        n_cmp++; if ({rf_addr, rf_we, rf_wdata, rf_wmask} !== '0) begin
            $display("FAIL idle_rf_bus: got addr %h we %b wdata %h wmask %h want all 0", rf_addr, rf_we, rf_wdata, rf_wmask); n_bad++; end
        n_cmp++; if (grant_id !== 2'd0) begin $display("FAIL idle_grant: got %0d want 0", grant_id); n_bad++; end
    endtask

    task automatic test_read_id();
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        step();
        n_cmp++; if (rf_addr !== 8'd0 || rf_we !== 1'b0) begin
            $display("FAIL id_access: got addr %h we %b want addr 00 we 0", rf_addr, rf_we); n_bad++; end
        n_cmp++; if (busy !== 1'b1) begin $display("FAIL id_busy: got %b want 1", busy); n_bad++; end
        step();
        n_cmp++; if (req_ack !== 3'b001) begin $display("FAIL id_ack: got %b want 001", req_ack); n_bad++; end
        n_cmp++; if (req_rdata[7:0] !== 8'h5A) begin $display("FAIL id_rdata: got %h want 5a", req_rdata[7:0]); n_bad++; end
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        step();
        n_cmp++; if (req_ack !== 3'b000 || busy !== 1'b0) begin
            $display("FAIL id_after: got ack %b busy %b want 000 0", req_ack, busy); n_bad++; end
        n_cmp++; if (req_rdata[7:0] !== 8'h5A) begin $display("FAIL id_hold: got %h want 5a", req_rdata[7:0]); n_bad++; end
        settle();
    endtask

    task automatic test_write_read();
        logic [N-1:0] ack;
        int cyc;
        drive(1, 1'b1, 1'b0, 1'b1, 8'd3, 32'hA5A5A5A5, 4'b0001);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 8'd3) begin
            $display("FAIL wr_access: got we %b addr %h want 1 03", rf_we, rf_addr); n_bad++; end
        n_cmp++; if (rf_wdata !== 32'hA5A5A5A5 || rf_wmask !== 4'b0001) begin
            $display("FAIL wr_data: got %h/%b want a5a5a5a5/0001", rf_wdata, rf_wmask); n_bad++; end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin $display("FAIL wr_we_pulse: got %b want 0", rf_we); n_bad++; end
        n_cmp++; if (req_ack !== 3'b010 || req_rdata !== 32'h0) begin
            $display("FAIL wr_ack: got ack %b rdata %h want 010 0", req_ack, req_rdata); n_bad++; end
        drive(1, 1'b1, 1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
        wait_ack(ack, cyc);
        n_cmp++; if (ack !== 3'b010 || cyc !== 3) begin
            $display("FAIL rd_ack: got ack %b after %0d cycles want 010 after 3", ack, cyc); n_bad++; end
        n_cmp++; if (req_rdata !== 32'h000000A5) begin $display("FAIL rd_data: got %h want 000000a5", req_rdata); n_bad++; end
        settle();
    endtask

    task automatic test_back_to_back();
        int exp_g [6] = '{0, 1, 0, 1, 0, 1};
        logic [N-1:0] ack;
        int cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            wait_ack(ack, cyc);
            n_cmp++; if (ack !== (3'b001 << exp_g[i]) || grant_id !== 2'(exp_g[i])) begin
                $display("FAIL b2b_grant[%0d]: got ack %b id %0d want id %0d", i, ack, grant_id, exp_g[i]); n_bad++; end
            n_cmp++; if (cyc !== ((i == 0) ? 2 : 3)) begin
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i, cyc, (i == 0) ? 2 : 3); n_bad++; end
        end
        settle();
    endtask

    task automatic test_lock();
        logic [N-1:0] ack;
        int cyc;
        drive(1, 1'b1, 1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
        for (int i = 0; i < 17; i++) begin
            wait_ack(ack, cyc);
            if (i == 0) drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
            n_cmp++; if (ack !== ((i < 16) ? 3'b010 : 3'b001)) begin
                $display("FAIL lock_ack[%0d]: got %b want %b", i, ack, (i < 16) ? 3'b010 : 3'b001); n_bad++; end
        end
        settle();
    endtask

    task automatic test_reset_mid_access();
        drive(0, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        step();
        n_cmp++; if (rf_we !== 1'b1) begin $display("FAIL mid_we_before: got %b want 1", rf_we); n_bad++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mid_async: got we %b busy %b want 0 0", rf_we, busy); n_bad++; end
        req = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (req_ack !== 3'b000) begin $display("FAIL mid_no_ack[%0d]: got %b want 000", i, req_ack); n_bad++; end
        end
        n_cmp++; if (mem[5] !== 32'h0) begin $display("FAIL mid_no_write: got %h want 0", mem[5]); n_bad++; end
    endtask

    task automatic test_three_way();
        int exp_g [6] = '{0, 1, 2, 0, 2, 0};
        logic [N-1:0] ack;
        int cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
        drive(2, 1'b1, 1'b0, 1'b0, 8'd5, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            wait_ack(ack, cyc);
            if (i == 1) req[1] = 1'b0;
            n_cmp++; if (ack !== (3'b001 << exp_g[i])) begin
                $display("FAIL rr3_order[%0d]: got %b want %b", i, ack, 3'b001 << exp_g[i]); n_bad++; end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_read();
        test_back_to_back();
        test_lock();
        test_reset_mid_access();
        test_three_way();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_bus_arbiter.md
Name: rf_bus_arbiter

Overview:
Shares the single register-file memory interface (addr/we/wdata/wmask/rdata) between NUM_REQ requesters, e.g. the SPI slave and an on-chip configuration sequencer.
- Round-robin arbitration over a req/ack handshake.
- Optional bounded lock, so one requester can issue atomic multi-word sequences such as a multi-byte DAC or bias update.
- Sits between the requesters and the register file; the register file's write is registered and its read is combinational.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
LOCK_MAX, 16, maximum consecutive accesses a locked requester may take before a forced release (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester access request; held until ack
req_lock  in  NUM_REQ  requester asks to keep the grant after this access
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*`RF_AWIDTH  flattened word addresses, requester i at [i*`RF_AWIDTH +: `RF_AWIDTH]
req_wdata  in  NUM_REQ*`RF_WIDTH  flattened write data
req_wmask  in  NUM_REQ*`RF_MASK  flattened byte-enable masks
req_ack  out  NUM_REQ  one-cycle completion pulse to the served requester
req_rdata  out  `RF_WIDTH  read data, valid while any req_ack bit is high
rf_addr  out  `RF_AWIDTH  to register file addr
rf_we  out  1  to register file we
rf_wdata  out  `RF_WIDTH  to register file wdata
rf_wmask  out  `RF_MASK  to register file wmask
rf_rdata  in  `RF_WIDTH  from register file rdata (combinational)
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the requester currently or last served

Behaviour:
- All outputs are registered. Reset is asynchronous on rst high and forces:
  - state = IDLE
  - rf_we = 0, rf_addr = 0, rf_wdata = 0, rf_wmask = 0
  - req_ack = 0, req_rdata = 0, busy = 0, grant_id = 0
  - last_grant = NUM_REQ-1, so requester 0 wins first
  - lock_valid = 0, lock_cnt = 0
- FSM states:
  - IDLE:
    - If lock_valid and req[grant_id], select grant_id.
    - Else if lock_valid and !req[grant_id], clear lock_valid and lock_cnt, then arbitrate in the same cycle.
    - Else round-robin: the first asserted req scanning from last_grant+1 upward, with wrap.
    - On a selection, latch index, we, addr, wdata and wmask, then go to ACCESS. With no req, stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - rf_addr, rf_wdata and rf_wmask are driven from the latches; rf_we equals the latched we.
    - At the cycle end, capture rf_rdata for reads, or 0 for writes. The write has not landed yet, so pre-write data is never returned.
    - Go to ACK. rf_we returns to 0 on leaving ACCESS, so each write is exactly one cycle and is never duplicated.
  - ACK (1 cycle):
    - req_ack[idx] = 1 and req_rdata = the captured value; last_grant = idx.
    - Lock update:
      - If req_lock[idx] is high and lock_cnt+1 < LOCK_MAX: lock_valid = 1, lock_cnt++.
      - Otherwise: lock_valid = 0, lock_cnt = 0 (forced release on reaching LOCK_MAX).
    - Go to IDLE.
- Latency and throughput:
  - req high in cycle N (state IDLE) gives rf access in cycle N+1 and req_ack in cycle N+2.
  - Peak throughput is one access per 3 cycles.
- req_rdata is held until the next ACK. req_ack is 0 in all states except ACK.
- Requester drops req before its ack: the latched transaction still completes and the ack still pulses. Request fields are sampled only in IDLE; changes afterwards are ignored.
- Simultaneous requests: resolved strictly by rotation. A requester cannot be served twice in a row while another is pending, unless a lock is held.
- Lock fairness: after a forced release, last_grant = the locked index, so the next pending requester wins.
- Reset mid-ACCESS: rf_we drops asynchronously and the in-flight access is abandoned with no ack.

Decomposition:
- Package rf_arb_pkg:
  - state enum {IDLE, ACCESS, ACK}
  - localparam IDX_W = $clog2(NUM_REQ) helper function
  - lock counter width localparam (8 bits)
- Sub-module rr_pick (combinational):
  - Inputs: req vector and last_grant.
  - Outputs: one-hot/index of the next requester plus a valid flag.
  - Implemented as a rotate, priority-encode, un-rotate.

Test Plan:
- Reset held, then released with no req -> all outputs 0, busy 0. Assert rst mid-ACCESS of a write -> rf_we falls the same cycle and no req_ack follows.
- req[0] read addr 0 in cycle N -> rf_addr = 0 and rf_we = 0 at N+1; req_ack = 2'b01 at N+2 with req_rdata[7:0] = `CHIP_ID`.
- req[1] write addr 3, wdata 0xA5A5A5A5, wmask 4'b0001, then read addr 3 -> rf_we high exactly one cycle; readback byte0 = 0xA5; req_rdata for the write ack = 0.
- req[0] and req[1] both held for 6 accesses -> grant_id sequence 0,1,0,1,0,1; acks spaced 3 cycles apart.
- req[1] with req_lock held, req[0] pending, LOCK_MAX = 16 -> 16 consecutive acks to requester 1, then requester 0 is served next.
- NUM_REQ = 3, all requesting, requester 1 drops req after its first grant -> order 0,1,2,0,2,0 with no ack to 1 after the drop.
